// File: rtl/pgm_pkg.sv
// Shared constants and types for the pgm receive monitor: beat types, FSM encodings, field widths.
`timescale 1ns/1ps
package pgm_pkg;

  localparam logic [1:0] BEAT_HEAD = 2'b01;
  localparam logic [1:0] BEAT_BODY = 2'b11;
  localparam logic [1:0] BEAT_TAIL = 2'b10;

  localparam int DATA_W = 134;
  localparam int PHV_W  = 1024;
  localparam int INV_W  = 4;
  localparam int BEAT_W = 16;
  localparam int LEN_W  = BEAT_W + 5;

  typedef enum logic [2:0] {
    RUN_IDLE  = 3'd0,
    RUN_ARMED = 3'd1,
    RUN_RUN   = 3'd2,
    RUN_DRAIN = 3'd3,
    RUN_DONE  = 3'd4
  } run_state_t;

  typedef enum logic {
    PARSE_WAIT_HEAD = 1'b0,
    PARSE_IN_PKT    = 1'b1
  } parse_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/pgm_rx_parse.sv
// Beat framing checker: tracks head/body/tail sequencing and emits a registered
// one-cycle pkt_end pulse with keep flag and byte length, plus framing error count.
`timescale 1ns/1ps
module pgm_rx_parse
  import pgm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_wr,
  input  logic [1:0]       beat_type,
  input  logic [INV_W-1:0] inv,
  input  logic             valid_wr,
  input  logic             valid,
  output logic             pkt_end,
  output logic             pkt_keep,
  output logic [LEN_W-1:0] pkt_len,
  output logic [1:0]       err_num,
  output logic             idle
);

  parse_state_t      state_reg, state_next;
  logic [BEAT_W-1:0] beats_reg, beats_next;
  logic              end_reg, end_next;
  logic              keep_reg, keep_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  tail_len;
  logic [1:0]        err_reg, err_next;
  logic              is_tail;
  logic              frame_err;
  logic              vwr_err;

  assign is_tail  = data_wr && (beat_type == BEAT_TAIL);
  // beats counts everything before the tail, so the tail adds one more 16-byte beat
  assign tail_len = {({1'b0, beats_reg} + (BEAT_W+1)'(1)), 4'b0000} - LEN_W'(inv);

  always_comb begin
    state_next = state_reg;
    beats_next = beats_reg;
    end_next   = 1'b0;
    keep_next  = 1'b0;
    len_next   = '0;
    frame_err  = 1'b0;
    vwr_err    = 1'b0;
    if (data_wr) begin
      case (beat_type)
        BEAT_HEAD: begin
          frame_err  = (state_reg == PARSE_IN_PKT);
          state_next = PARSE_IN_PKT;
          beats_next = BEAT_W'(1);
        end
        BEAT_BODY: begin
          if (state_reg == PARSE_WAIT_HEAD) begin
            frame_err = 1'b1;
          end else if (beats_reg != '1) begin
            beats_next = beats_reg + BEAT_W'(1);
          end
        end
        BEAT_TAIL: begin
          if (state_reg == PARSE_WAIT_HEAD) begin
            frame_err = 1'b1;
          end else begin
            state_next = PARSE_WAIT_HEAD;
            if (valid_wr) begin
              end_next  = 1'b1;
              keep_next = valid;
              len_next  = valid ? tail_len : '0;
            end else begin
              frame_err = 1'b1;
            end
          end
        end
        default: frame_err = 1'b1;
      endcase
    end
    if (valid_wr && !is_tail) begin
      vwr_err = 1'b1;
    end
    err_next = {1'b0, frame_err} + {1'b0, vwr_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PARSE_WAIT_HEAD;
      beats_reg <= '0;
      end_reg   <= 1'b0;
      keep_reg  <= 1'b0;
      len_reg   <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beats_reg <= beats_next;
      end_reg   <= end_next;
      keep_reg  <= keep_next;
      len_reg   <= len_next;
      err_reg   <= err_next;
    end
  end

  assign pkt_end  = end_reg;
  assign pkt_keep = keep_reg;
  assign pkt_len  = len_reg;
  assign err_num  = err_reg;
  assign idle     = (state_reg == PARSE_WAIT_HEAD);

endmodule

// File: rtl/pgm_rx_mon.sv
// Terminal receiver for pgm traffic: framing/sequence checks, statistics, run tracking.
// Define PGM_RX_LAT_EN to build the PHV timestamp latency measurement.
`timescale 1ns/1ps
module pgm_rx_mon
  import pgm_pkg::*;
#(
  parameter logic [7:0] LMID    = 8'd7,
  parameter int         SEQ_LSB = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_rx_data_wr,
  input  logic [DATA_W-1:0] in_rx_data,
  input  logic              in_rx_valid_wr,
  input  logic              in_rx_valid,
  output logic              out_rx_alf,
  input  logic [PHV_W-1:0]  in_rx_phv,
  input  logic              in_rx_phv_wr,
  output logic              out_rx_phv_alf,
  input  logic              in_rx_start_flag,
  input  logic              in_rx_finish_flag,
  input  logic              cfg_rx_clear,
  input  logic              cfg_rx_pause,
  output logic [31:0]       out_rx_pkt_cnt,
  output logic [31:0]       out_rx_drop_cnt,
  output logic [47:0]       out_rx_byte_cnt,
  output logic [15:0]       out_rx_err_cnt,
  output logic              out_rx_err,
  output logic              out_rx_busy,
  output logic              out_rx_done,
  output logic [31:0]       out_rx_lat_last,
  output logic [31:0]       out_rx_lat_max,
  output logic [7:0]        out_rx_mid
);

  logic             parse_end;
  logic             parse_keep;
  logic [LEN_W-1:0] parse_len;
  logic [1:0]       parse_err;
  logic             parse_idle;

  pgm_rx_parse u_parse (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_wr  (in_rx_data_wr),
    .beat_type(in_rx_data[133:132]),
    .inv      (in_rx_data[131:128]),
    .valid_wr (in_rx_valid_wr),
    .valid    (in_rx_valid),
    .pkt_end  (parse_end),
    .pkt_keep (parse_keep),
    .pkt_len  (parse_len),
    .err_num  (parse_err),
    .idle     (parse_idle)
  );

  logic data_unused;
  logic phv_unused;
  assign data_unused = ^in_rx_data[127:0];
  assign phv_unused  = ^in_rx_phv;

  logic [1:0] alf_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alf_reg <= 2'b00;
    else        alf_reg <= {2{cfg_rx_pause}};
  end
  assign out_rx_alf     = alf_reg[0];
  assign out_rx_phv_alf = alf_reg[1];

  // Expected seq after any PHV is always seq+1, whether it matched or resynced.
  logic [31:0] exp_seq_reg, exp_seq_next, exp_seq_eff, seq_in;
  logic        seq_err;
  assign seq_in      = in_rx_phv[SEQ_LSB +: 32];
  assign exp_seq_eff = (in_rx_start_flag || cfg_rx_clear) ? 32'd0 : exp_seq_reg;
  assign seq_err     = in_rx_phv_wr && (seq_in != exp_seq_eff);
  assign exp_seq_next = in_rx_phv_wr ? (seq_in + 32'd1) : exp_seq_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_seq_reg <= '0;
    else        exp_seq_reg <= exp_seq_next;
  end

  // At most two framing errors plus one sequence error, so the sum already caps at 3.
  logic [1:0]  err_inc;
  logic [31:0] pkt_cnt_reg, drop_cnt_reg;
  logic [47:0] byte_cnt_reg;
  logic [15:0] err_cnt_reg;
  logic        err_reg;
  assign err_inc = parse_err + {1'b0, seq_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      err_reg      <= 1'b0;
    end else if (cfg_rx_clear) begin
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (parse_end && parse_keep) begin
        pkt_cnt_reg  <= pkt_cnt_reg + 32'd1;
        byte_cnt_reg <= byte_cnt_reg + 48'(parse_len);
      end
      if (parse_end && !parse_keep) begin
        drop_cnt_reg <= drop_cnt_reg + 32'd1;
      end
      if (err_inc != 2'd0) begin
        err_cnt_reg <= sat_add16(err_cnt_reg, err_inc);
        err_reg     <= 1'b1;
      end
    end
  end

  assign out_rx_pkt_cnt  = pkt_cnt_reg;
  assign out_rx_drop_cnt = drop_cnt_reg;
  assign out_rx_byte_cnt = byte_cnt_reg;
  assign out_rx_err_cnt  = err_cnt_reg;
  assign out_rx_err      = err_reg;

  // Per-run PHV and pkt-end tallies decide when a drained run is complete.
  logic [31:0] run_phv_cnt_reg, run_end_cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_phv_cnt_reg <= '0;
      run_end_cnt_reg <= '0;
    end else if (in_rx_start_flag) begin
      run_phv_cnt_reg <= {31'b0, in_rx_phv_wr};
      run_end_cnt_reg <= '0;
    end else begin
      run_phv_cnt_reg <= run_phv_cnt_reg + {31'b0, in_rx_phv_wr};
      run_end_cnt_reg <= run_end_cnt_reg + {31'b0, parse_end};
    end
  end

  run_state_t run_reg, run_next;
  logic       head_in, drained;
  assign head_in = in_rx_data_wr && (in_rx_data[133:132] == BEAT_HEAD);
  assign drained = parse_idle && !parse_end && (run_phv_cnt_reg == run_end_cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_reg <= RUN_IDLE;
    else        run_reg <= run_next;
  end

  always_comb begin
    run_next = run_reg;
    if (in_rx_start_flag) begin
      run_next = RUN_ARMED;
    end else begin
      case (run_reg)
        RUN_ARMED: begin
          if (in_rx_finish_flag) run_next = RUN_DONE;
          else if (head_in)      run_next = RUN_RUN;
        end
        RUN_RUN:   if (in_rx_finish_flag) run_next = RUN_DRAIN;
        RUN_DRAIN: if (drained)           run_next = RUN_DONE;
        default:   run_next = run_reg;
      endcase
    end
    out_rx_busy = (run_reg == RUN_ARMED) || (run_reg == RUN_RUN) || (run_reg == RUN_DRAIN);
    out_rx_done = (run_reg == RUN_DONE);
  end

`ifdef PGM_RX_LAT_EN
  logic [31:0] now_reg, lat_last_reg, lat_max_reg, lat_cur;
  assign lat_cur = now_reg - in_rx_phv[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_reg      <= '0;
      lat_last_reg <= '0;
      lat_max_reg  <= '0;
    end else begin
      now_reg <= now_reg + 32'd1;
      if (cfg_rx_clear) begin
        lat_last_reg <= '0;
        lat_max_reg  <= '0;
      end else if (in_rx_phv_wr) begin
        lat_last_reg <= lat_cur;
        if (lat_cur > lat_max_reg) lat_max_reg <= lat_cur;
      end
    end
  end
  assign out_rx_lat_last = lat_last_reg;
  assign out_rx_lat_max  = lat_max_reg;
`else
  assign out_rx_lat_last = 32'd0;
  assign out_rx_lat_max  = 32'd0;
`endif

  assign out_rx_mid = LMID;

endmodule

// File: tb/tb_pgm_rx_mon.sv
// Self-checking bench for pgm_rx_mon: scoreboard of expected counter snapshots per scenario.
`timescale 1ns/1ps
module tb_pgm_rx_mon;
  import pgm_pkg::*;

  localparam int SEQ_LSB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_wr = 1'b0;
  logic [133:0]  data = '0;
  logic          valid_wr = 1'b0;
  logic          valid = 1'b0;
  logic [1023:0] phv = '0;
  logic          phv_wr = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          clear = 1'b0;
  logic          pause = 1'b0;

  logic        alf, phv_alf, err_flag, busy, done;
  logic [31:0] pkt_cnt, drop_cnt, lat_last, lat_max;
  logic [47:0] byte_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  mid;

  pgm_rx_mon #(.LMID(8'd7), .SEQ_LSB(SEQ_LSB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rx_data_wr(data_wr), .in_rx_data(data),
    .in_rx_valid_wr(valid_wr), .in_rx_valid(valid),
    .out_rx_alf(alf), .in_rx_phv(phv), .in_rx_phv_wr(phv_wr), .out_rx_phv_alf(phv_alf),
    .in_rx_start_flag(start), .in_rx_finish_flag(finish),
    .cfg_rx_clear(clear), .cfg_rx_pause(pause),
    .out_rx_pkt_cnt(pkt_cnt), .out_rx_drop_cnt(drop_cnt), .out_rx_byte_cnt(byte_cnt),
    .out_rx_err_cnt(err_cnt), .out_rx_err(err_flag), .out_rx_busy(busy), .out_rx_done(done),
    .out_rx_lat_last(lat_last), .out_rx_lat_max(lat_max), .out_rx_mid(mid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [31:0] pkt;
    logic [31:0] drop;
    logic [47:0] byt;
    logic [15:0] err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pkt = 0, m_drop = 0, m_exp = 0;
  logic [47:0] m_byte = 0;
  logic [15:0] m_err = 0;

  task automatic model_err(input int n);
    int t;
    t = int'(m_err) + n;
    m_err = (t > 65535) ? 16'hFFFF : 16'(t);
  endtask

  task automatic model_zero();
    m_pkt = 0; m_drop = 0; m_byte = 0; m_err = 0; m_exp = 0;
  endtask

  task automatic push_exp();
    sb.push_back('{pkt: m_pkt, drop: m_drop, byt: m_byte, err: m_err});
  endtask

  task automatic idle_in();
    @(negedge clk);
    data_wr = 0; valid_wr = 0; valid = 0; phv_wr = 0;
    start = 0; finish = 0; clear = 0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_beat(input logic [1:0] t, input logic [3:0] inv, input logic vwr, input logic v);
    @(negedge clk);
    phv_wr = 0; start = 0; finish = 0; clear = 0;
    data_wr = 1; data = {t, inv, $urandom(), $urandom(), $urandom(), $urandom()};
    valid_wr = vwr; valid = v;
  endtask

  task automatic drive_phv(input logic [31:0] seq, input int lat_ofs);
    @(negedge clk);
    data_wr = 0; valid_wr = 0; valid = 0; start = 0; finish = 0; clear = 0;
    phv = '0;
    phv[SEQ_LSB +: 32] = seq;
    phv[31:0] = (lat_ofs > 0) ? 32'(cyc - lat_ofs) : 32'h0;
    phv_wr = 1;
    if (seq != m_exp) model_err(1);
    m_exp = seq + 1;
  endtask

  task automatic send_pkt(input int nbeats, input logic [3:0] inv, input logic v,
                          input logic [31:0] seq, input int lat_ofs);
    drive_beat(BEAT_HEAD, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < nbeats - 2; i++) drive_beat(BEAT_BODY, 4'h0, 1'b0, 1'b0);
    drive_beat(BEAT_TAIL, inv, 1'b1, v);
    if (v) begin
      m_pkt++;
      m_byte += 48'(nbeats * 16 - int'(inv));
    end else begin
      m_drop++;
    end
    drive_phv(seq, lat_ofs);
    idle_in();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    data_wr = 0; valid_wr = 0; phv_wr = 0; start = 1;
    m_exp = 0;
    idle_in();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    data_wr = 0; valid_wr = 0; phv_wr = 0; clear = 1;
    model_zero();
    idle_in();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt, err_flag, busy, done, alf, phv_alf, lat_last, lat_max} !== '0) begin
      failures++;
      $display("FAIL reset_state got pkt=%0d drop=%0d byte=%0d err=%0d flag=%b busy=%b done=%b alf=%b/%b lat=%0d/%0d want all 0",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, err_flag, busy, done, alf, phv_alf, lat_last, lat_max);
    end
    checks++;
    if (mid !== 8'd7) begin
      failures++;
      $display("FAIL mid got %0d want 7", mid);
    end
    $display("reset: pkt=%0d err=%0d busy=%b", pkt_cnt, err_cnt, busy);
  endtask

  task automatic test_single_pkt();
    pulse_start();
    send_pkt(4, 4'd4, 1'b1, 32'd0, 0);
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL single_pkt got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL single_pkt_run got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    $display("single_pkt: pkt=%0d byte=%0d err=%0d", pkt_cnt, byte_cnt, err_cnt);
  endtask

  task automatic test_framing_err();
    drive_beat(BEAT_BODY, 4'h0, 1'b0, 1'b0);
    idle_in();
    model_err(1);
    settle();
    checks++;
    if ({err_cnt, err_flag} !== {m_err, 1'b1}) begin
      failures++;
      $display("FAIL stray_body got err=%0d flag=%b want err=%0d flag=1", err_cnt, err_flag, m_err);
    end
    send_pkt(2, 4'h0, 1'b1, m_exp, 0);
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL after_err_pkt got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    $display("framing_err: pkt=%0d byte=%0d err=%0d", pkt_cnt, byte_cnt, err_cnt);
  endtask

  task automatic test_seq();
    int seqs[4] = '{0, 1, 3, 4};
    pulse_clear();
    settle();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt, err_flag} !== '0) begin
      failures++;
      $display("FAIL clear got pkt=%0d drop=%0d byte=%0d err=%0d flag=%b want all 0",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, err_flag);
    end
    foreach (seqs[i]) send_pkt(2, 4'h0, 1'b1, 32'(seqs[i]), 0);
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL seq_gap got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    $display("seq: pkt=%0d err=%0d", pkt_cnt, err_cnt);
  endtask

  task automatic test_drop();
    send_pkt(3, 4'd5, 1'b0, m_exp, 0);
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL drop got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    $display("drop: pkt=%0d drop=%0d byte=%0d", pkt_cnt, drop_cnt, byte_cnt);
  endtask

  task automatic test_drain();
    drive_beat(BEAT_HEAD, 4'h0, 1'b0, 1'b0);
    drive_beat(BEAT_BODY, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    data_wr = 0; finish = 1;
    idle_in();
    settle();
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL drain_wait got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    drive_beat(BEAT_TAIL, 4'h0, 1'b1, 1'b1);
    m_pkt++;
    m_byte += 48'd48;
    drive_phv(m_exp, 0);
    idle_in();
    push_exp();
    settle();
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL drain_done got busy=%b done=%b want busy=0 done=1", busy, done);
    end
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL drain_counts got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    $display("drain: done=%b pkt=%0d byte=%0d", done, pkt_cnt, byte_cnt);
  endtask

  task automatic test_zero_run();
    @(negedge clk);
    start = 1; finish = 1;
    m_exp = 0;
    idle_in();
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL start_wins got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    @(negedge clk);
    finish = 1;
    idle_in();
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL zero_run got busy=%b done=%b want busy=0 done=1", busy, done);
    end
    $display("zero_run: busy=%b done=%b", busy, done);
  endtask

  task automatic test_pause();
    @(negedge clk);
    pause = 1;
    #1;
    checks++;
    if ({alf, phv_alf} !== 2'b00) begin
      failures++;
      $display("FAIL pause_latency got alf=%b phv_alf=%b want 0/0", alf, phv_alf);
    end
    @(negedge clk);
    checks++;
    if ({alf, phv_alf} !== 2'b11) begin
      failures++;
      $display("FAIL pause_on got alf=%b phv_alf=%b want 1/1", alf, phv_alf);
    end
    pause = 0;
    @(negedge clk);
    checks++;
    if ({alf, phv_alf} !== 2'b00) begin
      failures++;
      $display("FAIL pause_off got alf=%b phv_alf=%b want 0/0", alf, phv_alf);
    end
    $display("pause: alf=%b phv_alf=%b", alf, phv_alf);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    drive_beat(BEAT_HEAD, 4'h0, 1'b0, 1'b0);
    drive_beat(BEAT_BODY, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    data_wr = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_zero();
    checks++;
    if ({busy, done, pkt_cnt} !== {2'b00, 32'd0}) begin
      failures++;
      $display("FAIL reset_mid_state got busy=%b done=%b pkt=%0d want 0/0/0", busy, done, pkt_cnt);
    end
    send_pkt(2, 4'h0, 1'b1, 32'd0, 10);
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL reset_replay got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    checks++;
`ifdef PGM_RX_LAT_EN
    if ({lat_last, lat_max} !== {32'd10, 32'd10}) begin
      failures++;
      $display("FAIL latency got last=%0d max=%0d want 10/10", lat_last, lat_max);
    end
`else
    if ({lat_last, lat_max} !== 64'd0) begin
      failures++;
      $display("FAIL latency_off got last=%0d max=%0d want 0/0", lat_last, lat_max);
    end
`endif
    $display("reset_mid: pkt=%0d byte=%0d lat=%0d", pkt_cnt, byte_cnt, lat_last);
  endtask

  task automatic test_err_sat();
    pulse_clear();
    @(negedge clk);
    data_wr = 1; data = {BEAT_BODY, 4'h0, 128'h0};
    valid_wr = 1;
    phv = '0; phv[SEQ_LSB +: 32] = 32'd5; phv_wr = 1;
    idle_in();
    model_err(3);
    m_exp = 6;
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({pkt_cnt, drop_cnt, byte_cnt, err_cnt} !== {e.pkt, e.drop, e.byt, e.err}) begin
      failures++;
      $display("FAIL triple_err got pkt=%0d drop=%0d byte=%0d err=%0d want %0d/%0d/%0d/%0d",
               pkt_cnt, drop_cnt, byte_cnt, err_cnt, e.pkt, e.drop, e.byt, e.err);
    end
    @(negedge clk);
    data_wr = 1; data = {BEAT_BODY, 4'h0, 128'h0};
    valid_wr = 1;
    phv = '0; phv_wr = 1;
    repeat (21900) @(negedge clk);
    model_err(3 * 21900);
    idle_in();
    push_exp();
    settle();
    e = sb.pop_front();
    checks++;
    if ({err_cnt, err_flag} !== {e.err, 1'b1}) begin
      failures++;
      $display("FAIL err_saturate got err=%0d flag=%b want %0d/1", err_cnt, err_flag, e.err);
    end
    pulse_clear();
    settle();
    checks++;
    if ({err_cnt, err_flag} !== {16'd0, 1'b0}) begin
      failures++;
      $display("FAIL err_clear got err=%0d flag=%b want 0/0", err_cnt, err_flag);
    end
    $display("err_sat: err=%0d flag=%b", err_cnt, err_flag);
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_framing_err();
    test_seq();
    test_drop();
    test_drain();
    test_zero_run();
    test_pause();
    test_reset_mid();
    test_err_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
